fir_sample_bridge: RTL

FIR_SAMPLE_BRIDGE -- requirements
Module: fir_sample_bridge

---
 rtl/fir_sample_bridge.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/fir_sample_bridge.sv
`default_nettype none
//==============================================================================
// Module   : fir_sample_bridge
// Desc     : Frame-based bridge between a streaming sample source/sink and a
//            strobe-driven FIR core. Buffers input samples, feeds a frame of
//            FRAME_LEN samples followed by FLUSH_LEN zeros on FIR request
//            strobes, and captures the first FRAME_LEN FIR results into an
//            output FIFO. Sticky flags report input underrun and result
//            overflow.
// Revision : 1.0 - initial release
//==============================================================================
module fir_sample_bridge #(
    parameter int DATA_WIDTH = 16,
    parameter int IN_DEPTH   = 8,
    parameter int OUT_DEPTH  = 8,
    parameter int FRAME_LEN  = 64,
    parameter int FLUSH_LEN  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  fir_en,
    input  logic                  fir_sample_in,
    output logic [DATA_WIDTH-1:0] fir_din,
    input  logic                  fir_sample_out,
    input  logic [DATA_WIDTH-1:0] fir_dout,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  underrun,
    output logic                  overflow
);

    // Pointer widths; depths are powers of two (>= 2) so pointers wrap naturally.
    localparam int c_IN_AW    = (IN_DEPTH  > 1) ? $clog2(IN_DEPTH)  : 1;
    localparam int c_OUT_AW   = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int c_SENT_MAX = (FRAME_LEN > FLUSH_LEN) ? FRAME_LEN : FLUSH_LEN;
    localparam int c_SENT_W   = $clog2(c_SENT_MAX + 1);
    localparam int c_CAP_W    = $clog2(FRAME_LEN + 1);

    localparam logic [c_IN_AW:0]    c_IN_FULL    = (c_IN_AW + 1)'(IN_DEPTH);
    localparam logic [c_OUT_AW:0]   c_OUT_FULL   = (c_OUT_AW + 1)'(OUT_DEPTH);
    localparam logic [c_SENT_W-1:0] c_FEED_LAST  = c_SENT_W'(FRAME_LEN - 1);
    localparam logic [c_SENT_W-1:0] c_FLUSH_LAST = c_SENT_W'(FLUSH_LEN - 1);
    localparam logic [c_CAP_W-1:0]  c_CAP_TOTAL  = c_CAP_W'(FRAME_LEN);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FEED  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                  state_q, state_d;

    logic [DATA_WIDTH-1:0]   in_mem_q [IN_DEPTH];
    logic [DATA_WIDTH-1:0]   in_mem_d [IN_DEPTH];
    logic [c_IN_AW-1:0]      in_wr_q, in_wr_d;
    logic [c_IN_AW-1:0]      in_rd_q, in_rd_d;
    logic [c_IN_AW:0]        in_cnt_q, in_cnt_d;

    logic [DATA_WIDTH-1:0]   out_mem_q [OUT_DEPTH];
    logic [DATA_WIDTH-1:0]   out_mem_d [OUT_DEPTH];
    logic [c_OUT_AW-1:0]     out_wr_q, out_wr_d;
    logic [c_OUT_AW-1:0]     out_rd_q, out_rd_d;
    logic [c_OUT_AW:0]       out_cnt_q, out_cnt_d;

    logic [c_SENT_W-1:0]     sent_q, sent_d;
    logic [c_CAP_W-1:0]      cap_q, cap_d;
    logic [DATA_WIDTH-1:0]   fir_din_q, fir_din_d;
    logic                    underrun_q, underrun_d;
    logic                    overflow_q, overflow_d;

    logic                    w_in_full;
    logic                    w_in_empty;
    logic                    w_in_push;
    logic                    w_in_pop;
    logic                    w_out_full;
    logic                    w_out_push;
    logic                    w_out_pop;
    logic                    w_cap_window;

    // Status decode; s_ready is based on the pre-pop occupancy.
    assign w_in_full    = (in_cnt_q == c_IN_FULL);
    assign w_in_empty   = (in_cnt_q == '0);
    assign w_in_push    = s_valid && !w_in_full;
    assign w_out_full   = (out_cnt_q == c_OUT_FULL);
    assign w_out_pop    = (out_cnt_q != '0) && m_ready;
    assign w_cap_window = (state_q == ST_FEED) || (state_q == ST_FLUSH) ||
                          (state_q == ST_DRAIN);

    assign s_ready  = !w_in_full;
    assign fir_en   = (state_q == ST_FEED) || (state_q == ST_FLUSH);
    assign fir_din  = fir_din_q;
    assign m_data   = out_mem_q[out_rd_q];
    assign m_valid  = (out_cnt_q != '0);
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign underrun = underrun_q;
    assign overflow = overflow_q;

    // Frame sequencing: next state, FIR feed data, counters, sticky flags.
    always_comb begin
        state_d    = state_q;
        sent_d     = sent_q;
        cap_d      = cap_q;
        fir_din_d  = fir_din_q;
        underrun_d = underrun_q;
        overflow_d = overflow_q;
        w_in_pop   = 1'b0;
        w_out_push = 1'b0;

        case (state_q)
            ST_IDLE: begin
                fir_din_d = '0;
                if (start) begin
                    state_d    = ST_FEED;
                    sent_d     = '0;
                    cap_d      = '0;
                    underrun_d = 1'b0;
                    overflow_d = 1'b0;
                end
            end
            ST_FEED: begin
                if (fir_sample_in) begin
                    sent_d = sent_q + c_SENT_W'(1);
                    if (w_in_empty) begin
                        // Slot is consumed with a zero; it is never retried.
                        fir_din_d  = '0;
                        underrun_d = 1'b1;
                    end else begin
                        fir_din_d = in_mem_q[in_rd_q];
                        w_in_pop  = 1'b1;
                    end
                    if (sent_q == c_FEED_LAST) begin
                        state_d = ST_FLUSH;
                        sent_d  = '0;
                    end
                end
            end
            ST_FLUSH: begin
                if (fir_sample_in) begin
                    fir_din_d = '0;
                    sent_d    = sent_q + c_SENT_W'(1);
                    if (sent_q == c_FLUSH_LAST) begin
                        state_d = ST_DRAIN;
                        sent_d  = '0;
                    end
                end
            end
            ST_DRAIN: begin
                fir_din_d = '0;
                if (cap_q == c_CAP_TOTAL) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                fir_din_d = '0;
                state_d   = ST_IDLE;
            end
            default: begin
                fir_din_d = '0;
                state_d   = ST_IDLE;
            end
        endcase

        // Only the first FRAME_LEN results of a frame are kept; a full output
        // FIFO with no pop this cycle drops the result but still counts it.
        if (w_cap_window && fir_sample_out && (cap_q < c_CAP_TOTAL)) begin
            cap_d = cap_q + c_CAP_W'(1);
            if (w_out_full && !w_out_pop) begin
                overflow_d = 1'b1;
            end else begin
                w_out_push = 1'b1;
            end
        end
    end

    // Input FIFO next-state: write at tail, read at head, occupancy count.
    always_comb begin
        in_mem_d = in_mem_q;
        in_wr_d  = in_wr_q;
        in_rd_d  = in_rd_q;
        in_cnt_d = in_cnt_q;
        if (w_in_push) begin
            in_mem_d[in_wr_q] = s_data;
            in_wr_d           = in_wr_q + c_IN_AW'(1);
        end
        if (w_in_pop) begin
            in_rd_d = in_rd_q + c_IN_AW'(1);
        end
        case ({w_in_push, w_in_pop})
            2'b10:   in_cnt_d = in_cnt_q + (c_IN_AW + 1)'(1);
            2'b01:   in_cnt_d = in_cnt_q - (c_IN_AW + 1)'(1);
            default: in_cnt_d = in_cnt_q;
        endcase
    end

    // Output FIFO next-state; a push on a full FIFO with a same-cycle pop
    // overwrites the slot being read out, which is safe since m_data is read
    // combinationally before the edge.
    always_comb begin
        out_mem_d = out_mem_q;
        out_wr_d  = out_wr_q;
        out_rd_d  = out_rd_q;
        out_cnt_d = out_cnt_q;
        if (w_out_push) begin
            out_mem_d[out_wr_q] = fir_dout;
            out_wr_d            = out_wr_q + c_OUT_AW'(1);
        end
        if (w_out_pop) begin
            out_rd_d = out_rd_q + c_OUT_AW'(1);
        end
        case ({w_out_push, w_out_pop})
            2'b10:   out_cnt_d = out_cnt_q + (c_OUT_AW + 1)'(1);
            2'b01:   out_cnt_d = out_cnt_q - (c_OUT_AW + 1)'(1);
            default: out_cnt_d = out_cnt_q;
        endcase
    end

    // Control and pointer registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            in_wr_q    <= '0;
            in_rd_q    <= '0;
            in_cnt_q   <= '0;
            out_wr_q   <= '0;
            out_rd_q   <= '0;
            out_cnt_q  <= '0;
            sent_q     <= '0;
            cap_q      <= '0;
            fir_din_q  <= '0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_wr_q    <= in_wr_d;
            in_rd_q    <= in_rd_d;
            in_cnt_q   <= in_cnt_d;
            out_wr_q   <= out_wr_d;
            out_rd_q   <= out_rd_d;
            out_cnt_q  <= out_cnt_d;
            sent_q     <= sent_d;
            cap_q      <= cap_d;
            fir_din_q  <= fir_din_d;
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage; contents are don't-care while the counts read empty.
    always_ff @(posedge clk) begin
        in_mem_q  <= in_mem_d;
        out_mem_q <= out_mem_d;
    end

endmodule
`default_nettype wire
